decode_issue: RTL and testbench

Decode/issue stage directly upstream of the 16-bit ALU. It accepts 16-bit instruction words over a valid/ready handshake, and fetches a second word for immediate-format operations. It reads a 16×16 register file, with bypass from the writeback port, and holds instructions whose registers are still awaited from writeback. It then presents `codop`, `operando1`, `operando2` and `imm` to the ALU, together with a one-cycle `alu_valid` and the destination index that writeback uses.

---
 rtl/decode_issue.sv | 174 +++++++++++++++++
 tb/tb_decode_issue.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue.sv
// decode_issue: decode/issue stage in front of the 16-bit ALU.
//
// Accepts 16-bit instruction words on a valid/ready handshake. Immediate-
// format operations (codop 6-10) take the next accepted word as their imm.
// Operands are read from a 16x16 register file, with a same-cycle bypass
// from the writeback port. A per-register pending scoreboard holds an
// instruction until the registers it depends on have been written back.
// Issued values are registered onto the ALU outputs together with a
// one-cycle alu_valid pulse.
//
// Handshake: a word transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready depends only on the FSM state and
// never on instr_valid. The upstream stage holds instr_data stable while
// instr_valid is high and the word has not yet transferred.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   instr_valid/ready     upstream handshake
//   instr_data[15:0]      opcode word {codop, rd, rs1, rs2} or immediate word
//   wb_en/addr/data       writeback port (register write and pending clear)
//   codop, operando1,
//   operando2, imm, dest  ALU inputs and the destination index; they hold
//                         their last issued values between issues
//   alu_valid             one-cycle pulse: a new instruction has issued
//   illegal               one-cycle pulse: a word with codop 11-15 was dropped
//
// The FSM state is kept in the named signal 'state' so checkers can bind to it.
module decode_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr_data,
  output logic        instr_ready,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic [3:0]  codop,
  output logic [15:0] operando1,
  output logic [15:0] operando2,
  output logic [15:0] imm,
  output logic [3:0]  dest,
  output logic        alu_valid,
  output logic        illegal
);

  typedef enum logic [1:0] {S_OP, S_IMM, S_CHECK} state_t;

  state_t      state, state_nxt;
  logic [15:0] word_q;
  logic [15:0] imm_q;
  logic [15:0] regs [16];
  logic [15:0] pending;

  logic        hs;
  logic [3:0]  in_codop;
  logic        in_illegal;
  logic        in_itype;
  logic [3:0]  op_c, op_rd, op_rs1, op_rs2;
  logic        op_is_r;
  logic [15:0] rs1_val, rs2_val;
  logic [15:0] wb_clear;
  logic [15:0] pend_eff;
  logic [15:0] set_mask;
  logic        hazard;
  logic        issue;

  assign in_codop   = instr_data[15:12];
  assign in_illegal = (in_codop >= 4'd11);
  assign in_itype   = (in_codop >= 4'd6) && (in_codop <= 4'd10);

  assign op_c    = word_q[15:12];
  assign op_rd   = word_q[11:8];
  assign op_rs1  = word_q[7:4];
  assign op_rs2  = word_q[3:0];
  // Only legal words ever reach S_CHECK, so anything not R-type is I-type.
  assign op_is_r = (op_c <= 4'd5);

  // Register reads: R0 is hardwired to zero; a writeback to the same
  // non-zero index in this cycle is forwarded.
  always_comb begin
    rs1_val = regs[op_rs1];
    rs2_val = regs[op_rs2];
    if (wb_en && (wb_addr == op_rs1)) rs1_val = wb_data;
    if (wb_en && (wb_addr == op_rs2)) rs2_val = wb_data;
    if (op_rs1 == 4'd0) rs1_val = 16'd0;
    if (op_rs2 == 4'd0) rs2_val = 16'd0;
  end

  // A pending bit being cleared this cycle no longer blocks: its value
  // arrives through the bypass above.
  assign wb_clear = wb_en ? (16'd1 << wb_addr) : 16'd0;
  assign pend_eff = pending & ~wb_clear;
  assign hazard   = pend_eff[op_rs1] | (op_is_r & pend_eff[op_rs2]) | pend_eff[op_rd];
  assign issue    = (state == S_CHECK) && !hazard;
  assign set_mask = (issue && (op_rd != 4'd0)) ? (16'd1 << op_rd) : 16'd0;

  always_comb begin
    instr_ready = 1'b0;
    state_nxt   = state;
    case (state)
      S_OP: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (in_illegal)    state_nxt = S_OP;
          else if (in_itype) state_nxt = S_IMM;
          else               state_nxt = S_CHECK;
        end
      end
      S_IMM: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        instr_ready = 1'b0;
        if (!hazard) state_nxt = S_OP;
      end
      default: state_nxt = S_OP;
    endcase
  end

  assign hs = instr_valid & instr_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_OP;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= 16'd0;
      imm_q  <= 16'd0;
    end else begin
      if ((state == S_OP) && hs)  word_q <= instr_data;
      if ((state == S_IMM) && hs) imm_q  <= instr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= 16'd0;
    end else if (wb_en && (wb_addr != 4'd0)) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Set takes priority over a same-cycle clear; bit 0 is never pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= 16'd0;
    else       pending <= ((pending & ~wb_clear) | set_mask) & 16'hFFFE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      codop     <= 4'd0;
      operando1 <= 16'd0;
      operando2 <= 16'd0;
      imm       <= 16'd0;
      dest      <= 4'd0;
      alu_valid <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      alu_valid <= issue;
      illegal   <= (state == S_OP) && hs && in_illegal;
      if (issue) begin
        codop     <= op_c;
        operando1 <= op_is_r ? rs1_val : 16'd0;
        operando2 <= op_is_r ? rs2_val : rs1_val;
        imm       <= op_is_r ? 16'd0 : imm_q;
        dest      <= op_rd;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed and randomized bench for decode_issue.
// Inputs change 1 ns after a rising edge; outputs are sampled on the
// falling edge.
module tb_decode_issue;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic        instr_ready;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [3:0]  codop;
  logic [15:0] operando1;
  logic [15:0] operando2;
  logic [15:0] imm;
  logic [3:0]  dest;
  logic        alu_valid;
  logic        illegal;

  int checks = 0;
  int passed = 0;

  // Reference model: architectural register values and outstanding results.
  logic [15:0] m_regs [16];
  bit          m_pend [16];

  decode_issue dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .codop(codop), .operando1(operando1), .operando2(operando2), .imm(imm),
    .dest(dest), .alu_valid(alu_valid), .illegal(illegal)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 16'd0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic model_wb(input logic [3:0] a, input logic [15:0] d);
    if (a != 4'd0) m_regs[a] = d;
    m_pend[a] = 1'b0;
  endtask

  task automatic model_issue(input logic [3:0] rd);
    if (rd != 4'd0) m_pend[rd] = 1'b1;
  endtask

  // ---------------- drivers ----------------
  // Presents one word and waits (bounded) for it to transfer.
  task automatic send_word(input logic [15:0] w);
    int n = 0;
    instr_valid = 1'b1;
    instr_data  = w;
    @(negedge clk);
    while (!instr_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (instr_ready !== 1'b1) $display("FAIL handshake_timeout: word %h never accepted", w);
    else passed++;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_data  = 16'($urandom);
  endtask

  task automatic drive_wb(input logic [3:0] a, input logic [15:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk); #1;
    wb_en = 1'b0;
    model_wb(a, d);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; instr_valid = 1'b0; instr_data = 16'd0;
    wb_en = 1'b0; wb_addr = 4'd0; wb_data = 16'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (alu_valid !== 1'b0) $display("FAIL reset_alu_valid: got %b want 0", alu_valid); else passed++;
    checks++; if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", illegal); else passed++;
    checks++; if ({codop, dest} !== 8'd0) $display("FAIL reset_codop_dest: got %h want 00", {codop, dest}); else passed++;
    checks++; if ({operando1, operando2, imm} !== 48'd0) $display("FAIL reset_operands: got %h want 0", {operando1, operando2, imm}); else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", instr_ready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    drive_wb(4'd1, 16'd5);
    drive_wb(4'd2, 16'd7);
    send_word(16'h0312);
    @(negedge clk);
    checks++; if (alu_valid !== 1'b0) $display("FAIL rtype_early_valid: got %b want 0", alu_valid); else passed++;
    checks++; if (instr_ready !== 1'b0) $display("FAIL rtype_check_ready: got %b want 0", instr_ready); else passed++;
    @(negedge clk);
    checks++; if (alu_valid !== 1'b1) $display("FAIL rtype_valid: got %b want 1", alu_valid); else passed++;
    checks++; if (codop !== 4'd0) $display("FAIL rtype_codop: got %h want 0", codop); else passed++;
    checks++; if (operando1 !== 16'd5) $display("FAIL rtype_op1: got %h want 0005", operando1); else passed++;
    checks++; if (operando2 !== 16'd7) $display("FAIL rtype_op2: got %h want 0007", operando2); else passed++;
    checks++; if (imm !== 16'd0) $display("FAIL rtype_imm: got %h want 0000", imm); else passed++;
    checks++; if (dest !== 4'd3) $display("FAIL rtype_dest: got %h want 3", dest); else passed++;
    checks++; if (instr_ready !== 1'b1) $display("FAIL rtype_ready_after: got %b want 1", instr_ready); else passed++;
    model_issue(4'd3);
    @(negedge clk);
    checks++; if (alu_valid !== 1'b0) $display("FAIL rtype_pulse_width: got %b want 0", alu_valid); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_itype();
    send_word(16'h9410);
    @(negedge clk);
    checks++; if (alu_valid !== 1'b0) $display("FAIL itype_no_early_issue: got %b want 0", alu_valid); else passed++;
    checks++; if (instr_ready !== 1'b1) $display("FAIL itype_imm_ready: got %b want 1", instr_ready); else passed++;
    @(posedge clk); #1;
    send_word(16'h1234);
    @(negedge clk);
    checks++; if (alu_valid !== 1'b0) $display("FAIL itype_check_cycle: got %b want 0", alu_valid); else passed++;
    @(negedge clk);
    checks++; if (alu_valid !== 1'b1) $display("FAIL itype_valid: got %b want 1", alu_valid); else passed++;
    checks++; if (codop !== 4'd9) $display("FAIL itype_codop: got %h want 9", codop); else passed++;
    checks++; if (operando1 !== 16'd0) $display("FAIL itype_op1: got %h want 0000", operando1); else passed++;
    checks++; if (operando2 !== 16'd5) $display("FAIL itype_op2: got %h want 0005", operando2); else passed++;
    checks++; if (imm !== 16'h1234) $display("FAIL itype_imm: got %h want 1234", imm); else passed++;
    checks++; if (dest !== 4'd4) $display("FAIL itype_dest: got %h want 4", dest); else passed++;
    model_issue(4'd4);
    @(posedge clk); #1;
  endtask

  task automatic test_raw();
    // R3 is still awaiting writeback from the ADD in test_rtype.
    send_word(16'h1530);
    repeat (3) begin
      @(negedge clk);
      checks++; if (alu_valid !== 1'b0) $display("FAIL raw_stall_valid: got %b want 0", alu_valid); else passed++;
      checks++; if (instr_ready !== 1'b0) $display("FAIL raw_stall_ready: got %b want 0", instr_ready); else passed++;
    end
    @(posedge clk); #1;
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 16'h00AA;
    @(negedge clk);
    checks++; if (alu_valid !== 1'b0) $display("FAIL raw_wb_cycle: got %b want 0", alu_valid); else passed++;
    @(posedge clk); #1;
    wb_en = 1'b0;
    model_wb(4'd3, 16'h00AA);
    @(negedge clk);
    checks++; if (alu_valid !== 1'b1) $display("FAIL raw_valid: got %b want 1", alu_valid); else passed++;
    checks++; if (codop !== 4'd1) $display("FAIL raw_codop: got %h want 1", codop); else passed++;
    checks++; if (operando1 !== 16'h00AA) $display("FAIL raw_bypass_op1: got %h want 00aa", operando1); else passed++;
    checks++; if (operando2 !== 16'd0) $display("FAIL raw_op2: got %h want 0000", operando2); else passed++;
    checks++; if (dest !== 4'd5) $display("FAIL raw_dest: got %h want 5", dest); else passed++;
    model_issue(4'd5);
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    send_word(16'hB000);
    @(negedge clk);
    checks++; if (illegal !== 1'b1) $display("FAIL illegal_pulse: got %b want 1", illegal); else passed++;
    checks++; if (alu_valid !== 1'b0) $display("FAIL illegal_no_issue: got %b want 0", alu_valid); else passed++;
    checks++; if (instr_ready !== 1'b1) $display("FAIL illegal_ready: got %b want 1", instr_ready); else passed++;
    checks++; if (operando1 !== 16'h00AA) $display("FAIL illegal_hold_op1: got %h want 00aa", operando1); else passed++;
    @(negedge clk);
    checks++; if (illegal !== 1'b0) $display("FAIL illegal_width: got %b want 0", illegal); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_imm();
    send_word(16'h9410);
    #2 reset = 1'b1;
    #1;
    checks++; if ({codop, dest} !== 8'd0) $display("FAIL rst_imm_codop_dest: got %h want 00", {codop, dest}); else passed++;
    checks++; if ({operando1, operando2, imm} !== 48'd0) $display("FAIL rst_imm_operands: got %h want 0", {operando1, operando2, imm}); else passed++;
    checks++; if ({alu_valid, illegal} !== 2'b00) $display("FAIL rst_imm_pulses: got %b want 00", {alu_valid, illegal}); else passed++;
    checks++; if (instr_ready !== 1'b1) $display("FAIL rst_imm_ready: got %b want 1", instr_ready); else passed++;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    send_word(16'h0312);
    @(negedge clk);
    checks++; if (alu_valid !== 1'b0) $display("FAIL rst_imm_check_cycle: got %b want 0", alu_valid); else passed++;
    @(negedge clk);
    checks++; if (alu_valid !== 1'b1) $display("FAIL rst_imm_valid: got %b want 1", alu_valid); else passed++;
    checks++; if (codop !== 4'd0) $display("FAIL rst_imm_as_opcode: got %h want 0", codop); else passed++;
    checks++; if (imm !== 16'd0) $display("FAIL rst_imm_imm: got %h want 0000", imm); else passed++;
    checks++; if (operando1 !== 16'd0) $display("FAIL rst_imm_regs_cleared: got %h want 0000", operando1); else passed++;
    model_issue(4'd3);
    @(posedge clk); #1;
  endtask

  task automatic test_r0();
    drive_wb(4'd0, 16'hFFFF);
    send_word(16'h0200);
    @(negedge clk);
    checks++; if (alu_valid !== 1'b0) $display("FAIL r0_check_cycle: got %b want 0", alu_valid); else passed++;
    @(negedge clk);
    checks++; if (alu_valid !== 1'b1) $display("FAIL r0_no_stall: got %b want 1", alu_valid); else passed++;
    checks++; if (operando1 !== 16'd0) $display("FAIL r0_op1: got %h want 0000", operando1); else passed++;
    checks++; if (operando2 !== 16'd0) $display("FAIL r0_op2: got %h want 0000", operando2); else passed++;
    checks++; if (dest !== 4'd2) $display("FAIL r0_dest: got %h want 2", dest); else passed++;
    model_issue(4'd2);
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int it = 0; it < 60; it++) begin
      logic [3:0]  c, rd, rs1, rs2, wa;
      logic [15:0] w, iv, wd, e1, e2, ei;
      logic [3:0]  need [$];
      bit          is_r, is_i, do_wb, dup;
      need.delete();
      c   = 4'($urandom_range(0, 15));
      rd  = 4'($urandom);
      rs1 = 4'($urandom);
      rs2 = 4'($urandom);
      w   = {c, rd, rs1, rs2};
      is_r = (c <= 4'd5);
      is_i = (c >= 4'd6) && (c <= 4'd10);
      send_word(w);
      if (!is_r && !is_i) begin
        @(negedge clk);
        checks++; if (illegal !== 1'b1) $display("FAIL rand_illegal: word %h got %b want 1", w, illegal); else passed++;
        checks++; if (alu_valid !== 1'b0) $display("FAIL rand_illegal_issue: word %h got %b want 0", w, alu_valid); else passed++;
        @(posedge clk); #1;
      end else begin
        iv = 16'($urandom);
        if (is_i) send_word(iv);
        // Registers this instruction must wait for.
        if (m_pend[rs1]) need.push_back(rs1);
        if (is_r && m_pend[rs2] && rs2 != rs1) need.push_back(rs2);
        dup = (rd == rs1) || (is_r && rd == rs2);
        if (m_pend[rd] && !dup) need.push_back(rd);
        if (need.size() == 0) begin
          do_wb = ($urandom_range(0, 1) == 1);
          wa = 4'($urandom);
          wd = 16'($urandom);
          if (do_wb) begin
            wb_en = 1'b1; wb_addr = wa; wb_data = wd;
          end
          @(negedge clk);
          checks++; if (alu_valid !== 1'b0) $display("FAIL rand_check_cycle: word %h got %b want 0", w, alu_valid); else passed++;
          @(posedge clk); #1;
          wb_en = 1'b0;
          if (do_wb) model_wb(wa, wd);
        end else begin
          foreach (need[k]) begin
            repeat ($urandom_range(0, 2)) begin
              @(negedge clk);
              checks++; if (alu_valid !== 1'b0) $display("FAIL rand_stall: word %h got %b want 0", w, alu_valid); else passed++;
              @(posedge clk); #1;
            end
            wd = 16'($urandom);
            wb_en = 1'b1; wb_addr = need[k]; wb_data = wd;
            @(negedge clk);
            checks++; if (alu_valid !== 1'b0) $display("FAIL rand_stall_wb: word %h got %b want 0", w, alu_valid); else passed++;
            @(posedge clk); #1;
            wb_en = 1'b0;
            model_wb(need[k], wd);
          end
        end
        e1 = is_r ? m_regs[rs1] : 16'd0;
        e2 = is_r ? m_regs[rs2] : m_regs[rs1];
        ei = is_r ? 16'd0 : iv;
        @(negedge clk);
        checks++; if (alu_valid !== 1'b1) $display("FAIL rand_valid: word %h got %b want 1", w, alu_valid); else passed++;
        checks++; if (codop !== c) $display("FAIL rand_codop: word %h got %h want %h", w, codop, c); else passed++;
        checks++; if (operando1 !== e1) $display("FAIL rand_op1: word %h got %h want %h", w, operando1, e1); else passed++;
        checks++; if (operando2 !== e2) $display("FAIL rand_op2: word %h got %h want %h", w, operando2, e2); else passed++;
        checks++; if (imm !== ei) $display("FAIL rand_imm: word %h got %h want %h", w, imm, ei); else passed++;
        checks++; if (dest !== rd) $display("FAIL rand_dest: word %h got %h want %h", w, dest, rd); else passed++;
        model_issue(rd);
        @(posedge clk); #1;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_raw();
    test_illegal();
    test_reset_in_imm();
    test_r0();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
